logic_pod_ram_writer: RTL and testbench

//  Drains one logic pod's address FIFO (29b entries) and 256b data FIFO, in the clk_ram domain, into the DDR

---
 rtl/logic_pod_ram_writer.sv | 94 +++++++++
 tb/tb_logic_pod_ram_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pod_ram_writer.sv
// logic_pod_ram_writer: drains pod address/data FIFOs into DDR app write bursts of one command and two beats
module logic_pod_ram_writer #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk_ram,
  input  logic                  rst,
  input  logic                  addr_fifo_empty,
  output logic                  addr_fifo_rd_en,
  input  logic [ADDR_WIDTH-1:0] addr_fifo_rd_data,
  input  logic [9:0]            data_fifo_rd_size,
  output logic                  data_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] data_fifo_rd_data,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  output logic [31:0]           burst_count,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, POP, LOAD0, LOAD1, SEND} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdf_data_q, beat1_q;
  logic en_q, wren_q, end_q;
  logic [31:0] burst_count_q;
  logic start, cmd_done, data_done, done;
  assign start = !addr_fifo_empty && data_fifo_rd_size >= 10'd2;
  // command and data channels finish independently; the burst ends when both have
  assign cmd_done = !en_q || app_rdy;
  assign data_done = !wren_q || (end_q && app_wdf_rdy);
  assign done = state_q == SEND && cmd_done && data_done;
  always_ff @(posedge clk_ram) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    addr_fifo_rd_en = 1'b0;
    data_fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: state_d = start ? POP : IDLE;
      POP: begin
        addr_fifo_rd_en = 1'b1;
        data_fifo_rd_en = 1'b1;
        state_d = LOAD0;
      end
      LOAD0: begin
        data_fifo_rd_en = 1'b1;
        state_d = LOAD1;
      end
      LOAD1: state_d = SEND;
      SEND: state_d = done ? (start ? POP : IDLE) : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_ram) begin
    if (rst) begin
      addr_q <= '0;
      wdf_data_q <= '0;
      beat1_q <= '0;
      en_q <= 1'b0;
      wren_q <= 1'b0;
      end_q <= 1'b0;
      burst_count_q <= '0;
    end else begin
      burst_count_q <= burst_count_q + 32'(done);
      if (state_q == LOAD0) begin
        addr_q <= addr_fifo_rd_data;
        wdf_data_q <= data_fifo_rd_data;
      end
      if (state_q == LOAD1) begin
        beat1_q <= data_fifo_rd_data;
        en_q <= 1'b1;
        wren_q <= 1'b1;
      end
      if (en_q && app_rdy) en_q <= 1'b0;
      if (wren_q && app_wdf_rdy) begin
        wdf_data_q <= end_q ? wdf_data_q : beat1_q;
        end_q <= !end_q;
        wren_q <= !end_q;
      end
    end
  end
  assign app_en = en_q;
  assign app_cmd = 3'b000;
  assign app_addr = addr_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_data = wdf_data_q;
  assign app_wdf_end = end_q;
  assign burst_count = burst_count_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_logic_pod_ram_writer.sv
// tb_logic_pod_ram_writer: FIFO emulation plus an in-order burst scoreboard under randomized ready lines
module tb_logic_pod_ram_writer;
  localparam int AW = 29;
  localparam int DW = 256;
  logic clk_ram = 1'b0;
  logic rst = 1'b1;
  logic addr_fifo_empty, addr_fifo_rd_en, data_fifo_rd_en;
  logic [AW-1:0] addr_fifo_rd_data, app_addr;
  logic [9:0] data_fifo_rd_size;
  logic [DW-1:0] data_fifo_rd_data, app_wdf_data;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, busy;
  logic [2:0] app_cmd;
  logic [31:0] burst_count;
  always #5 clk_ram = ~clk_ram;
  logic_pod_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_ram(clk_ram), .rst(rst),
    .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd_en(addr_fifo_rd_en), .addr_fifo_rd_data(addr_fifo_rd_data),
    .data_fifo_rd_size(data_fifo_rd_size), .data_fifo_rd_en(data_fifo_rd_en), .data_fifo_rd_data(data_fifo_rd_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .burst_count(burst_count), .busy(busy)
  );
  logic [AW-1:0] aq[$], ea[$];
  logic [DW-1:0] dq[$], ed[$];
  int checks = 0, passed = 0;
  int c_n = 0, b_n = 0, done_n = 0, cyc = 0, last_cmd = -1;
  int a_pops = 0, d_pops = 0, en_hi = 0, wr_hi = 0, na = 0, nd = 0;
  int p_cmd = 100, p_wdf = 100;
  bit gap_chk = 1'b0;
  logic [31:0] model_cnt = '0;
  logic prev_en_wait = 1'b0, prev_wr_wait = 1'b0, prev_end = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction
  task automatic sync();
    addr_fifo_empty = aq.size() == 0;
    data_fifo_rd_size = 10'(dq.size());
  endtask
  task automatic push_a(input logic [AW-1:0] a);
    aq.push_back(a);
    ea.push_back(a);
    na++;
    sync();
  endtask
  task automatic push_d(input logic [DW-1:0] d);
    dq.push_back(d);
    ed.push_back(d);
    nd++;
    sync();
  endtask
  task automatic push_burst();
    push_a(AW'($urandom));
    push_d(rnd_d());
    push_d(rnd_d());
  endtask
  task automatic cycle();
    logic [AW-1:0] a_nx = '0;
    logic [DW-1:0] d_nx = '0;
    logic [AW-1:0] ax;
    logic [DW-1:0] dx;
    logic pa, pd;
    @(negedge clk_ram);
    cyc++;
    if (!rst) begin
      chk("burst_count", burst_count, model_cnt);
      if (prev_en_wait) begin
        chk("en_held", app_en, 1);
        chk("addr_held", app_addr, prev_addr);
      end
      if (prev_wr_wait) begin
        chk("wren_held", app_wdf_wren, 1);
        chk("data_held", app_wdf_data, prev_data);
        chk("end_held", app_wdf_end, prev_end);
      end
    end
    app_rdy = $urandom_range(0, 99) < p_cmd;
    app_wdf_rdy = $urandom_range(0, 99) < p_wdf;
    prev_en_wait = !rst && app_en && !app_rdy;
    prev_wr_wait = !rst && app_wdf_wren && !app_wdf_rdy;
    prev_addr = app_addr;
    prev_data = app_wdf_data;
    prev_end = app_wdf_end;
    en_hi += int'(app_en);
    wr_hi += int'(app_wdf_wren);
    if (!rst && app_en && app_rdy) begin
      chk("cmd_code", app_cmd, 0);
      chk("cmd_expected", ea.size() > 0, 1);
      ax = ea.size() > 0 ? ea.pop_front() : '0;
      chk("addr", app_addr, ax);
      if (gap_chk && last_cmd >= 0) chk("cmd_gap", cyc - last_cmd, 5);
      last_cmd = cyc;
      c_n++;
    end
    if (!rst && app_wdf_wren && app_wdf_rdy) begin
      chk("beat_expected", ed.size() > 0, 1);
      dx = ed.size() > 0 ? ed.pop_front() : '0;
      chk("beat", app_wdf_data, dx);
      chk("wdf_end", app_wdf_end, b_n[0]);
      b_n++;
    end
    if (c_n > done_n && b_n >= 2 * (done_n + 1)) begin
      done_n++;
      model_cnt++;
    end
    pa = !rst && addr_fifo_rd_en;
    pd = !rst && data_fifo_rd_en;
    if (pa) begin
      a_pops++;
      chk("addr_pop_nonempty", aq.size() > 0, 1);
      if (aq.size() > 0) a_nx = aq.pop_front();
    end
    if (pd) begin
      d_pops++;
      chk("data_pop_nonempty", dq.size() > 0, 1);
      if (dq.size() > 0) d_nx = dq.pop_front();
    end
    sync();
    @(posedge clk_ram);
    #1;
    if (pa) addr_fifo_rd_data = a_nx;
    if (pd) data_fifo_rd_data = d_nx;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    aq.delete();
    dq.delete();
    ea.delete();
    ed.delete();
    c_n = 0;
    b_n = 0;
    done_n = 0;
    na = 0;
    nd = 0;
    model_cnt = '0;
    sync();
    cycle();
    chk("rst_app_en", app_en, 0);
    chk("rst_app_cmd", app_cmd, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_wdf_data", app_wdf_data, 0);
    chk("rst_wdf_end", app_wdf_end, 0);
    chk("rst_burst_count", burst_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_rd_en", addr_fifo_rd_en, 0);
    chk("rst_data_rd_en", data_fifo_rd_en, 0);
    rst = 1'b0;
    prev_en_wait = 1'b0;
    prev_wr_wait = 1'b0;
    a_pops = 0;
    d_pops = 0;
    en_hi = 0;
    wr_hi = 0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((ea.size() > 0 || ed.size() > 0 || busy) && n < lim) begin
      cycle();
      n++;
    end
    chk("drain_in_time", n < lim, 1);
  endtask
  task automatic wait_beat0(input int lim);
    int n = 0;
    while (b_n < 1 && n < lim) begin
      cycle();
      n++;
    end
    chk("beat0_in_time", b_n >= 1, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    addr_fifo_rd_data = '0;
    data_fifo_rd_data = '0;
    do_reset();
    push_a(29'h1800_0004);
    push_d(rnd_d());
    push_d(rnd_d());
    drain(50);
    chk("t1_count", burst_count, 1);
    chk("t1_addr_pops", a_pops, 1);
    chk("t1_data_pops", d_pops, 2);
    chk("t1_en_cycles", en_hi, 1);
    chk("t1_wren_cycles", wr_hi, 2);
    do_reset();
    for (int i = 0; i < 4; i++) push_burst();
    last_cmd = -1;
    gap_chk = 1'b1;
    drain(100);
    gap_chk = 1'b0;
    chk("t2_count", burst_count, 4);
    chk("t2_addr_pops", a_pops, 4);
    chk("t2_data_pops", d_pops, 8);
    do_reset();
    push_burst();
    p_cmd = 0;
    wait_beat0(20);
    p_wdf = 0;
    for (int i = 0; i < 3; i++) cycle();
    p_wdf = 100;
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_waiting_for_cmd", burst_count, 0);
    chk("t3_busy", busy, 1);
    p_cmd = 100;
    drain(50);
    chk("t3_count", burst_count, 1);
    chk("t3_addr_pops", a_pops, 1);
    chk("t3_data_pops", d_pops, 2);
    do_reset();
    push_a(AW'($urandom));
    push_d(rnd_d());
    for (int i = 0; i < 8; i++) cycle();
    chk("t4_idle", busy, 0);
    chk("t4_addr_pops", a_pops, 0);
    chk("t4_data_pops", d_pops, 0);
    push_d(rnd_d());
    cycle();
    chk("t4_started", busy, 1);
    chk("t4_pop", addr_fifo_rd_en, 1);
    drain(50);
    chk("t4_count", burst_count, 1);
    push_burst();
    p_cmd = 0;
    wait_beat0(20);
    do_reset();
    p_cmd = 100;
    push_burst();
    drain(50);
    chk("t5_count", burst_count, 1);
    model_cnt = 32'hFFFF_FFFF;
    force dut.burst_count_q = 32'hFFFF_FFFF;
    cycle();
    cycle();
    release dut.burst_count_q;
    push_burst();
    drain(50);
    chk("t6_wrap", burst_count, 0);
    do_reset();
    p_cmd = 60;
    p_wdf = 60;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 15) push_a(AW'($urandom));
      if ($urandom_range(0, 99) < 30 && nd < 2 * na + 4) push_d(rnd_d());
      cycle();
    end
    while (na * 2 > nd) push_d(rnd_d());
    while (na * 2 < nd) push_a(AW'($urandom));
    drain(3000);
    chk("t7_count", burst_count, 32'(na));
    chk("t7_addr_pops", a_pops, na);
    chk("t7_data_pops", d_pops, nd);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
